circle_chase_sequencer: RTL and testbench



---
 rtl/circle_chase_pkg.sv | 16 +
 rtl/step_prescaler.sv | 43 ++++
 rtl/circle_chase_sequencer.sv | 158 +++++++++++++++
 tb/tb_circle_chase_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_chase_pkg.sv
// Shared types and constants for the circle chase sequencer.
package circle_chase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  localparam logic ROW_TOP = 1'b0;
  localparam logic ROW_BOT = 1'b1;

endpackage

// File: rtl/step_prescaler.sv
// Step prescaler: counts run cycles and raises step_en once every div_q+1
// counted cycles. div_q is re-latched from step_div on load and on each step.
module step_prescaler #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] step_div,
  output logic                 step_en
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 hit;

  assign hit     = (cnt_q == div_q);
  // clear wins over a coincident step
  assign step_en = run && !clr && hit;

  // Counter and divider latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      div_q <= step_div;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      if (hit) begin
        cnt_q <= '0;
        div_q <= step_div;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/circle_chase_sequencer.sv
// Circle chase sequencer: drives seg7_driver row/col so one lit segment
// chases around the display bank (top row left-to-right, bottom row back).
// Optional lap counter output `laps` is enabled by CIRCLE_CHASE_LAP_CNT_EN.
module circle_chase_sequencer
  import circle_chase_pkg::*;
#(
  parameter int DISPLAY_COUNT = 6,
  parameter int COL_WIDTH     = $clog2(DISPLAY_COUNT),
  parameter int DIV_WIDTH     = 24
`ifdef CIRCLE_CHASE_LAP_CNT_EN
  ,
  parameter int LAP_WIDTH     = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold,
  input  logic                 clear,
  input  logic                 dir,
  input  logic [DIV_WIDTH-1:0] step_div,
  output logic                 row,
  output logic [COL_WIDTH-1:0] col,
  output logic                 busy,
  output logic                 step_pulse,
  output logic                 lap_done
`ifdef CIRCLE_CHASE_LAP_CNT_EN
  ,
  output logic [LAP_WIDTH-1:0] laps
`endif
);

  localparam logic [COL_WIDTH-1:0] COL_MAX = COL_WIDTH'(DISPLAY_COUNT - 1);

  state_e               state_q, state_d;
  logic                 row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic                 busy_q;
  logic                 step_pulse_q, step_pulse_d;
  logic                 lap_done_q, lap_done_d;
  logic                 adv_row;
  logic [COL_WIDTH-1:0] adv_col;
  logic                 pre_run, pre_load, step_en;

  // Prescaler runs on cycles whose next state is RUN, so a falling hold
  // resumes counting immediately and a rising hold or stop freezes it at once.
  assign pre_load = (state_q == ST_IDLE) && (state_d == ST_RUN);
  assign pre_run  = (state_q != ST_IDLE) && (state_d == ST_RUN);

  step_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (pre_run),
    .clr      (clear),
    .load     (pre_load),
    .step_div (step_div),
    .step_en  (step_en)
  );

  // Control FSM next state; stop beats start and hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)      state_d = ST_IDLE;
        else if (hold) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)       state_d = ST_IDLE;
        else if (!hold) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next position around the circle and the strobes for it
  always_comb begin
    adv_row      = row_q;
    adv_col      = col_q;
    row_d        = row_q;
    col_d        = col_q;
    step_pulse_d = 1'b0;
    lap_done_d   = 1'b0;
    case (dir)
      DIR_CW: begin
        if (row_q == ROW_TOP) begin
          if (col_q == COL_MAX) adv_row = ROW_BOT;
          else                  adv_col = col_q + 1'b1;
        end else begin
          if (col_q == '0) adv_row = ROW_TOP;
          else             adv_col = col_q - 1'b1;
        end
      end
      DIR_CCW: begin
        if (row_q == ROW_TOP) begin
          if (col_q == '0) adv_row = ROW_BOT;
          else             adv_col = col_q - 1'b1;
        end else begin
          if (col_q == COL_MAX) adv_row = ROW_TOP;
          else                  adv_col = col_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (clear) begin
      row_d = ROW_TOP;
      col_d = '0;
    end else if (step_en) begin
      row_d        = adv_row;
      col_d        = adv_col;
      step_pulse_d = 1'b1;
      lap_done_d   = (adv_row == ROW_TOP) && (adv_col == '0);
    end
  end

  // State, position and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= ROW_TOP;
      col_q        <= '0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      lap_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= (state_d != ST_IDLE);
      step_pulse_q <= step_pulse_d;
      lap_done_q   <= lap_done_d;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign lap_done   = lap_done_q;

`ifdef CIRCLE_CHASE_LAP_CNT_EN
  logic [LAP_WIDTH-1:0] laps_q;

  // Lap counter, wraps naturally at 2^LAP_WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             laps_q <= '0;
    else if (clear)      laps_q <= '0;
    else if (lap_done_d) laps_q <= laps_q + 1'b1;
  end

  assign laps = laps_q;
`endif

endmodule

// File: tb/tb_circle_chase_sequencer.sv
// Directed bench for circle_chase_sequencer (N=6 displays).
module tb_circle_chase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hold = 1'b0;
  logic        clear = 1'b0;
  logic        dir = 1'b0;
  logic [23:0] step_div = '0;
  logic        row;
  logic [2:0]  col;
  logic        busy;
  logic        step_pulse;
  logic        lap_done;
`ifdef CIRCLE_CHASE_LAP_CNT_EN
  logic [7:0]  laps;
`endif

  int total = 0;
  int bad   = 0;

  // got/expected packed as {row, col[2:0], step_pulse, lap_done}
  logic [5:0] got;
  logic [5:0] exp_v;

  // CW order after (0,0)
  logic       cw_row [12] = '{0,0,0,0,0,1,1,1,1,1,1,0};
  logic [2:0] cw_col [12] = '{1,2,3,4,5,5,4,3,2,1,0,0};

  circle_chase_sequencer #(
    .DISPLAY_COUNT(6),
    .DIV_WIDTH(24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .clear      (clear),
    .dir        (dir),
    .step_div   (step_div),
    .row        (row),
    .col        (col),
    .busy       (busy),
    .step_pulse (step_pulse),
    .lap_done   (lap_done)
`ifdef CIRCLE_CHASE_LAP_CNT_EN
    ,
    .laps       (laps)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({row, col, busy, step_pulse, lap_done} !== 7'd0) begin
      bad++;
      $display("FAIL reset_vals: got %b want 0000000", {row, col, busy, step_pulse, lap_done});
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({row, col, busy, step_pulse, lap_done} !== 7'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 0000000", {row, col, busy, step_pulse, lap_done});
    end
  endtask

  task automatic test_cw_lap();
    dir = 1'b0; step_div = 24'd0; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({busy, row, col, step_pulse} !== 6'b100000) begin
      bad++;
      $display("FAIL cw_start: got %b want 100000", {busy, row, col, step_pulse});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      got   = {row, col, step_pulse, lap_done};
      exp_v = {cw_row[i], cw_col[i], 1'b1, (i == 11)};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL cw_step%0d: got %b want %b", i + 1, got, exp_v);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if ({busy, row, col, step_pulse} !== 6'b000000) begin
      bad++;
      $display("FAIL cw_stop: got %b want 000000", {busy, row, col, step_pulse});
    end
  endtask

  task automatic test_ccw_div3();
    logic [5:0] tbl [8];
    tbl = '{6'b000000, 6'b000000, 6'b000000, 6'b100010,
            6'b100000, 6'b100000, 6'b100000, 6'b100110};
    dir = 1'b1; step_div = 24'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      got = {row, col, step_pulse, lap_done};
      total++;
      if (got !== tbl[i]) begin
        bad++;
        $display("FAIL ccw_div3_cyc%0d: got %b want %b", i + 1, got, tbl[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({busy, row, col} !== 5'd0) begin
      bad++;
      $display("FAIL ccw_clear: got %b want 00000", {busy, row, col});
    end
  endtask

  task automatic test_hold_and_dir();
    logic       t_row [4] = '{0, 0, 0, 0};
    logic [2:0] t_col [4] = '{4, 5, 4, 3};
    dir = 1'b0; step_div = 24'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if ({row, col, step_pulse} !== 5'b00111) begin
      bad++;
      $display("FAIL hold_reach03: got %b want 00111", {row, col, step_pulse});
    end
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({busy, row, col, step_pulse} !== 6'b100110) begin
        bad++;
        $display("FAIL hold_frozen%0d: got %b want 100110", i, {busy, row, col, step_pulse});
      end
    end
    hold = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 2) dir = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick();
        exp_v = (c == 4) ? {t_row[s], t_col[s], 2'b10}
                         : {(s == 0) ? 1'b0 : t_row[s-1], (s == 0) ? 3'd3 : t_col[s-1], 2'b00};
        got = {row, col, step_pulse, lap_done};
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL resume_step%0d_cyc%0d: got %b want %b", s, c, got, exp_v);
        end
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_collisions();
    dir = 1'b0; step_div = 24'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    total++;
    if ({row, col} !== 4'b1000) begin
      bad++;
      $display("FAIL coll_at10: got %b want 1000", {row, col});
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({busy, row, col, step_pulse, lap_done} !== 7'b1000000) begin
      bad++;
      $display("FAIL clear_vs_step: got %b want 1000000", {busy, row, col, step_pulse, lap_done});
    end
    tick();
    total++;
    if ({row, col, step_pulse} !== 5'b00011) begin
      bad++;
      $display("FAIL after_clear_step: got %b want 00011", {row, col, step_pulse});
    end
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_start_busy: got %b want 0", busy);
    end
    tick();
    total++;
    if ({busy, row, col, step_pulse} !== 6'b000010) begin
      bad++;
      $display("FAIL stop_start_idle: got %b want 000010", {busy, row, col, step_pulse});
    end
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    dir = 1'b0; step_div = 24'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    total++;
    if ({busy, row, col} !== 5'b11010) begin
      bad++;
      $display("FAIL rst_at12: got %b want 11010", {busy, row, col});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({row, col, busy, step_pulse, lap_done} !== 7'd0) begin
      bad++;
      $display("FAIL async_rst: got %b want 0000000", {row, col, busy, step_pulse, lap_done});
    end
`ifdef CIRCLE_CHASE_LAP_CNT_EN
    total++;
    if (laps !== 8'd0) begin
      bad++;
      $display("FAIL async_rst_laps: got %0d want 0", laps);
    end
`endif
    tick();
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({row, col, busy, step_pulse} !== 6'd0) begin
      bad++;
      $display("FAIL post_rst_idle: got %b want 000000", {row, col, busy, step_pulse});
    end
  endtask

`ifdef CIRCLE_CHASE_LAP_CNT_EN
  task automatic test_laps();
    int pulses = 0;
    dir = 1'b0; step_div = 24'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (laps !== 8'd1) begin
      bad++;
      $display("FAIL laps_one: got %0d want 1", laps);
    end
    for (int i = 0; i < 255 * 12; i++) begin
      tick();
      if (lap_done === 1'b1) pulses++;
    end
    total++;
    if (laps !== 8'd0 || pulses != 255) begin
      bad++;
      $display("FAIL laps_wrap: got laps=%0d pulses=%0d want laps=0 pulses=255", laps, pulses);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_cw_lap();
    test_ccw_div3();
    test_hold_and_dir();
    test_collisions();
    test_async_reset();
`ifdef CIRCLE_CHASE_LAP_CNT_EN
    test_laps();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
